lsu_mem_stage: RTL

Load/store unit for the MEM stage of the 5-stage RISC-V core. It consumes the registered ALU result (effective address) and store operand at the EX/MEM boundary and drives a word-organised data memory through a req/ready handshake. It returns the aligned, sign- or zero-extended load value that feeds the MEM/WB writeback mux. It also stalls the pipeline while a memory access is outstanding.

---
 rtl/lsu_mem_stage.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: formats stores, drives a word memory via req/ready, formats loads.
// Latency: accept + >=1 ACCESS + 1 DONE cycle; stall holds the pipeline through accept and ACCESS.
module lsu_mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] Read_data,
  output logic        load_valid,
  output logic        stall,
  output logic        access_fault,
  output logic        bus_error
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;

  logic        op, legal, aligned, access_ok, timeout_hit;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_fmt;

  assign op          = MemRead | MemWrite;
  assign timeout_hit = (cnt_q == 8'(TIMEOUT - 1));

  always_comb begin
    legal = 1'b0;
    if (MemRead && MemWrite) begin
      legal = 1'b0;
    end else if (MemRead) begin
      case (funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
        default:                                legal = 1'b0;
      endcase
    end else begin
      case (funct3)
        3'b000, 3'b001, 3'b010: legal = 1'b1;
        default:                legal = 1'b0;
      endcase
    end
  end

  // funct3[1:0] encodes the access size for both loads and stores
  always_comb begin
    aligned = 1'b0;
    be_d    = 4'b1111;
    wdata_d = store_data;
    case (funct3[1:0])
      2'b00: begin
        aligned = 1'b1;
        be_d    = 4'b0001 << addr[1:0];
        wdata_d = {4{store_data[7:0]}};
      end
      2'b01: begin
        aligned = ~addr[0];
        be_d    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{store_data[15:0]}};
      end
      2'b10: begin
        aligned = (addr[1:0] == 2'b00);
        be_d    = 4'b1111;
        wdata_d = store_data;
      end
      default: begin
        aligned = 1'b0;
        be_d    = 4'b1111;
        wdata_d = store_data;
      end
    endcase
  end

  assign access_ok = legal & aligned;

  always_comb begin
    state_d      = state_q;
    stall        = 1'b0;
    mem_req      = 1'b0;
    access_fault = 1'b0;
    case (state_q)
      IDLE: begin
        if (op) begin
          if (access_ok) begin
            stall   = 1'b1;
            state_d = ACCESS;
          end else begin
            access_fault = 1'b1;
          end
        end
      end
      ACCESS: begin
        mem_req = 1'b1;
        stall   = 1'b1;
        if (mem_ready || timeout_hit) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    byte_sel = mem_rdata[7:0];
    case (off_q)
      2'd0: byte_sel = mem_rdata[7:0];
      2'd1: byte_sel = mem_rdata[15:8];
      2'd2: byte_sel = mem_rdata[23:16];
      2'd3: byte_sel = mem_rdata[31:24];
      default: byte_sel = mem_rdata[7:0];
    endcase
    half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  load_fmt = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_fmt = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_fmt = {24'd0, byte_sel};
      3'b101:  load_fmt = {16'd0, half_sel};
      default: load_fmt = mem_rdata;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      f3_q       <= 3'd0;
      off_q      <= 2'd0;
      mem_we     <= 1'b0;
      mem_be     <= 4'd0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      Read_data  <= 32'd0;
      load_valid <= 1'b0;
      bus_error  <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_valid <= 1'b0;
      if (state_q == IDLE && state_d == ACCESS) begin
        mem_addr  <= {addr[31:2], 2'b00};
        mem_we    <= MemWrite;
        mem_be    <= be_d;
        mem_wdata <= wdata_d;
        f3_q      <= funct3;
        off_q     <= addr[1:0];
        cnt_q     <= 8'd0;
      end
      if (state_q == ACCESS) begin
        if (mem_ready) begin
          cnt_q <= 8'd0;
          if (!mem_we) begin
            Read_data  <= load_fmt;
            load_valid <= 1'b1;
          end
        end else if (timeout_hit) begin
          cnt_q     <= 8'd0;
          bus_error <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
      end
    end
  end

endmodule
